// File: rtl/noc_flit_mux_rr.sv
// N:1 flit multiplexer with round-robin or fixed-port arbitration. A granted port stays locked from HEAD to TAIL.
// The winning flit is registered with valid/ready flow control. Define ACTIVITY_CNT_EN to enable the acnt toggle counter.
module noc_flit_mux_rr #(
    parameter int NUM_IN = 4,
    parameter int DATAW  = 66,
    parameter int VCHW   = 2,
    parameter int SELW   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATAW-1:0]  idata,
    input  logic [NUM_IN-1:0]        ivalid,
    input  logic [NUM_IN*VCHW-1:0]   ivch,
    output logic [NUM_IN-1:0]        iready,
    input  logic                     sel_mode,
    input  logic [SELW-1:0]          sel,
    output logic [DATAW-1:0]         odata,
    output logic                     ovalid,
    output logic [VCHW-1:0]          ovch,
    input  logic                     oready,
    output logic [31:0]              acnt
);
    localparam int IDXW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;
    localparam logic [1:0] TYPE_DATA = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   rrPtr_q, rrPtr_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [DATAW-1:0]  odata_q, odata_d;
    logic              ovalid_q, ovalid_d;
    logic [VCHW-1:0]   ovch_q, ovch_d;

    logic [DATAW-1:0]  flit [NUM_IN];
    logic [VCHW-1:0]   vch  [NUM_IN];
    logic [NUM_IN-1:0] isHead;
    logic [NUM_IN-1:0] grantVec;
    logic [IDXW-1:0]   grantIdx;
    logic [IDXW-1:0]   rrIdx;
    logic [IDXW-1:0]   selIdx;
    logic              grantAny;
    logic              load;
    logic              xfer;
    logic [DATAW-1:0]  winFlit;
    logic [VCHW-1:0]   winVch;
    logic [1:0]        winType;

    for (genvar g = 0; g < NUM_IN; g++) begin : gUnpack
        assign flit[g]   = idata[g*DATAW +: DATAW];
        assign vch[g]    = ivch[g*VCHW +: VCHW];
        assign isHead[g] = ivalid[g] && (idata[g*DATAW+DATAW-2 +: 2] == TYPE_HEAD);
    end

    assign load    = !ovalid_q || oready;
    assign selIdx  = sel[IDXW-1:0];
    assign winFlit = flit[grantIdx];
    assign winVch  = vch[grantIdx];
    assign winType = winFlit[DATAW-1 -: 2];

    // Descending scan so the candidate closest to rrPtr_q is assigned last and wins.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        rrIdx    = '0;
        if (state_q == LOCKED) begin
            grantIdx = owner_q;
            grantAny = (winType == TYPE_DATA) || (winType == TYPE_TAIL);
        end else if (sel_mode) begin
            if ((int'(sel) < NUM_IN) && isHead[selIdx]) begin
                grantAny = 1'b1;
                grantIdx = selIdx;
            end
        end else begin
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                rrIdx = IDXW'((int'(rrPtr_q) + k) % NUM_IN);
                if (isHead[rrIdx]) begin
                    grantAny = 1'b1;
                    grantIdx = rrIdx;
                end
            end
        end
    end

    always_comb begin
        grantVec = '0;
        if (grantAny) begin
            grantVec[grantIdx] = 1'b1;
        end
    end

    assign iready = (load && !rst) ? grantVec : '0;
    assign xfer   = grantAny && load && ivalid[grantIdx];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        if (xfer) begin
            if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = grantIdx;
            end else if (winType == TYPE_TAIL) begin
                state_d = IDLE;
                rrPtr_d = (owner_q == IDXW'(NUM_IN - 1)) ? '0 : owner_q + 1'b1;
            end
        end
    end

    // Data and VC hold their last value through bubbles; only valid drops.
    always_comb begin
        odata_d  = odata_q;
        ovch_d   = ovch_q;
        ovalid_d = ovalid_q;
        if (load) begin
            ovalid_d = xfer;
            if (xfer) begin
                odata_d = winFlit;
                ovch_d  = winVch;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rrPtr_q  <= '0;
            owner_q  <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ovch_q   <= '0;
        end else begin
            state_q  <= state_d;
            rrPtr_q  <= rrPtr_d;
            owner_q  <= owner_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ovch_q   <= ovch_d;
        end
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ovch   = ovch_q;

`ifdef ACTIVITY_CNT_EN
    logic [31:0] acnt_q, acnt_d;
    logic [32:0] acntSum;

    // Saturating accumulation of bits toggled by each accepted flit load.
    always_comb begin
        acntSum = {1'b0, acnt_q} + 33'($countones(odata_q ^ winFlit));
        acnt_d  = acnt_q;
        if (xfer) begin
            acnt_d = acntSum[32] ? 32'hFFFF_FFFF : acntSum[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acnt_q <= '0;
        end else begin
            acnt_q <= acnt_d;
        end
    end

    assign acnt = acnt_q;
`else
    assign acnt = 32'h0;
`endif

endmodule

// File: tb/tb_noc_flit_mux_rr.sv
// Self-checking bench for noc_flit_mux_rr: a vector table, directed corner sequences and randomized packets.
// All of it is compared against a packet-level reference model.
module tb_noc_flit_mux_rr;
    localparam int NUM_IN = 4;
    localparam int DATAW  = 66;
    localparam int VCHW   = 2;
    localparam int SELW   = 4;
    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_DATA = 2'b11;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN*DATAW-1:0] idata;
    logic [NUM_IN-1:0]       ivalid;
    logic [NUM_IN*VCHW-1:0]  ivch;
    logic [NUM_IN-1:0]       iready;
    logic                    sel_mode;
    logic [SELW-1:0]         sel;
    logic [DATAW-1:0]        odata;
    logic                    ovalid;
    logic [VCHW-1:0]         ovch;
    logic                    oready;
    logic [31:0]             acnt;

    always #5 clk = ~clk;

    noc_flit_mux_rr #(.NUM_IN(NUM_IN), .DATAW(DATAW), .VCHW(VCHW), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
        .sel_mode(sel_mode), .sel(sel), .odata(odata), .ovalid(ovalid), .ovch(ovch),
        .oready(oready), .acnt(acnt)
    );

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: packet lock flag, owner, round-robin pointer and the expected output register.
    bit               mLocked;
    int               mOwner;
    int               mRr;
    logic [DATAW-1:0] mOdata;
    logic             mOvalid;
    logic [VCHW-1:0]  mOvch;
    longint           mAcnt;
    logic [NUM_IN-1:0] expReady;
    bit               expLoad;
    bit               expXfer;
    int               expGrant;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] types;
        logic       ordy;
        logic [3:0] expRdy;
        logic       expOvalid;
    } vec_t;

    function automatic void modelReset();
        mLocked = 0; mOwner = 0; mRr = 0;
        mOdata = '0; mOvalid = 1'b0; mOvch = '0; mAcnt = 0;
    endfunction

    function automatic logic [1:0] typeOf(int p);
        return idata[p*DATAW+DATAW-2 +: 2];
    endfunction

    function automatic bit isHeadAt(int p);
        return ivalid[p] && (typeOf(p) == T_HEAD);
    endfunction

    function automatic void modelComb();
        int g;
        int p;
        g = -1;
        expLoad = !mOvalid || oready;
        if (mLocked) begin
            if (typeOf(mOwner) == T_DATA || typeOf(mOwner) == T_TAIL) g = mOwner;
        end else if (sel_mode) begin
            if (int'(sel) < NUM_IN && isHeadAt(int'(sel))) g = int'(sel);
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                p = (mRr + k) % NUM_IN;
                if (g < 0 && isHeadAt(p)) g = p;
            end
        end
        expReady = '0;
        expXfer  = 0;
        expGrant = g;
        if (expLoad && g >= 0) begin
            expReady[g] = 1'b1;
            expXfer = ivalid[g];
        end
    endfunction

    function automatic void modelSeq();
        logic [DATAW-1:0] f;
        if (expLoad) begin
            mOvalid = expXfer;
            if (expXfer) begin
                f = idata[expGrant*DATAW +: DATAW];
`ifdef ACTIVITY_CNT_EN
                mAcnt = mAcnt + $countones(f ^ mOdata);
                if (mAcnt > 64'hFFFF_FFFF) mAcnt = 64'hFFFF_FFFF;
`endif
                mOdata = f;
                mOvch  = ivch[expGrant*VCHW +: VCHW];
                if (!mLocked) begin
                    mLocked = 1;
                    mOwner  = expGrant;
                end else if (f[DATAW-1 -: 2] == T_TAIL) begin
                    mLocked = 0;
                    mRr     = (mOwner + 1) % NUM_IN;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setPort(input int p, input logic v, input logic [1:0] t, input logic [63:0] pay,
                           input logic [VCHW-1:0] vc);
        idata[p*DATAW +: DATAW] = {t, pay};
        ivalid[p] = v;
        ivch[p*VCHW +: VCHW] = vc;
    endtask

    task automatic clearPorts();
        for (int p = 0; p < NUM_IN; p++) setPort(p, 1'b0, T_NONE, 64'h0, '0);
    endtask

    task automatic checkOutput(input string name);
        check({name, "/ovalid"}, ovalid, mOvalid);
        check({name, "/odata"}, odata, mOdata);
        check({name, "/ovch"}, ovch, mOvch);
        check({name, "/acnt"}, acnt, mAcnt[31:0]);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic applyStimulus(input string name);
        #1;
        modelComb();
        check({name, "/iready"}, iready, expReady);
        @(posedge clk);
        modelSeq();
        #1;
        checkOutput(name);
        @(negedge clk);
    endtask

    vec_t vecs[10];
    int   pos[NUM_IN];
    int   len[NUM_IN];
    logic [DATAW-1:0] heldFlit;

    initial begin
        vecs[0] = '{4'b1101, 8'b01_01_00_01, 1'b1, 4'b0001, 1'b1};
        vecs[1] = '{4'b1101, 8'b01_01_00_11, 1'b1, 4'b0001, 1'b1};
        vecs[2] = '{4'b1101, 8'b01_01_00_10, 1'b1, 4'b0001, 1'b1};
        vecs[3] = '{4'b1100, 8'b01_01_00_00, 1'b1, 4'b0100, 1'b1};
        vecs[4] = '{4'b1100, 8'b01_10_00_00, 1'b1, 4'b0100, 1'b1};
        vecs[5] = '{4'b1000, 8'b01_00_00_00, 1'b1, 4'b1000, 1'b1};
        vecs[6] = '{4'b1000, 8'b10_00_00_00, 1'b0, 4'b0000, 1'b1};
        vecs[7] = '{4'b1000, 8'b10_00_00_00, 1'b1, 4'b1000, 1'b1};
        vecs[8] = '{4'b0000, 8'b00_00_00_00, 1'b1, 4'b0000, 1'b0};
        vecs[9] = '{4'b0010, 8'b00_00_11_00, 1'b1, 4'b0000, 1'b0};

        rst = 1'b1; oready = 1'b1; sel_mode = 1'b0; sel = '0;
        for (int p = 0; p < NUM_IN; p++) setPort(p, 1'b1, T_HEAD, {$urandom, $urandom}, VCHW'(p));
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/ovalid", ovalid, 1'b0);
        check("reset/odata", odata, '0);
        check("reset/iready", iready, '0);
        check("reset/acnt", acnt, '0);
        clearPorts();
        rst = 1'b0;
        repeat (2) applyStimulus("idle");

        // Round-robin order 0,2,3 with HEAD/DATA/TAIL, a stall and non-HEAD flits in IDLE.
        for (int i = 0; i < 10; i++) begin
            for (int p = 0; p < NUM_IN; p++)
                setPort(p, vecs[i].valid[p], vecs[i].types[2*p +: 2], 64'(p * 256 + i), VCHW'(p));
            oready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d/iready", i), iready, vecs[i].expRdy);
            applyStimulus($sformatf("vec%0d", i));
            check($sformatf("vec%0d/ovalidTbl", i), ovalid, vecs[i].expOvalid);
        end

        // Fixed select on port 1: 22-flit packet, others never ready.
        sel_mode = 1'b1; sel = 4'd1; oready = 1'b1;
        for (int p = 0; p < NUM_IN; p++) setPort(p, 1'b1, T_HEAD, 64'hA000 + 64'(p), VCHW'(p));
        for (int f = 0; f < 22; f++) begin
            setPort(1, 1'b1, (f == 0) ? T_HEAD : (f == 21) ? T_TAIL : T_DATA, 64'h1_0000 + 64'(f), 2'b10);
            applyStimulus("fixed1");
            check("fixed1/flit", odata, {(f == 0) ? T_HEAD : (f == 21) ? T_TAIL : T_DATA, 64'h1_0000 + 64'(f)});
            check("fixed1/ovch", ovch, 2'b10);
        end
        clearPorts();
        applyStimulus("drain1");

        // Lock port 2, then stall the output for 5 cycles mid-packet.
        sel_mode = 1'b0;
        setPort(2, 1'b1, T_HEAD, 64'h2_0000, 2'b01);
        applyStimulus("lock2/head");
        setPort(2, 1'b1, T_DATA, 64'h2_0001, 2'b01);
        applyStimulus("lock2/data");
        heldFlit = {T_DATA, 64'h2_0001};
        setPort(2, 1'b1, T_DATA, 64'h2_0002, 2'b01);
        oready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus("stall2");
            check("stall2/hold", odata, heldFlit);
        end
        oready = 1'b1;
        applyStimulus("lock2/data2");
        setPort(2, 1'b1, T_TAIL, 64'h2_0003, 2'b01);
        applyStimulus("lock2/tail");
        clearPorts();
        applyStimulus("drain2");

        // Port 1 locked in fixed mode; sel moves to 3 and owner re-presents a HEAD mid-packet.
        sel_mode = 1'b1; sel = 4'd1;
        setPort(1, 1'b1, T_HEAD, 64'h3_0000, 2'b11);
        applyStimulus("sw/head1");
        sel = 4'd3;
        setPort(3, 1'b1, T_HEAD, 64'h3_3000, 2'b00);
        setPort(1, 1'b1, T_DATA, 64'h3_0001, 2'b11);
        applyStimulus("sw/data1");
        check("sw/noPort3", iready[3], 1'b0);
        setPort(1, 1'b1, T_HEAD, 64'h3_0002, 2'b11);
        applyStimulus("sw/badHead");
        check("sw/badHeadRdy", iready, 4'b0000);
        setPort(1, 1'b1, T_TAIL, 64'h3_0003, 2'b11);
        applyStimulus("sw/tail1");
        setPort(1, 1'b0, T_NONE, 64'h0, 2'b11);
        applyStimulus("sw/head3");
        check("sw/port3out", odata, {T_HEAD, 64'h3_3000});

        // Reset in the middle of port 3's packet.
        setPort(3, 1'b1, T_DATA, 64'h3_3001, 2'b00);
        applyStimulus("rst/data3");
        rst = 1'b1;
        #1;
        check("midrst/ovalid", ovalid, 1'b0);
        check("midrst/odata", odata, '0);
        check("midrst/iready", iready, '0);
        check("midrst/acnt", acnt, '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        clearPorts();
        sel_mode = 1'b0; sel = '0;
        applyStimulus("postrst");

        // Randomized legal packets, random valids, back-pressure and mode/select changes.
        for (int p = 0; p < NUM_IN; p++) begin pos[p] = 0; len[p] = $urandom_range(0, 3); end
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NUM_IN; p++)
                setPort(p, ($urandom_range(0, 3) != 0),
                        (pos[p] == 0) ? T_HEAD : (pos[p] <= len[p]) ? T_DATA : T_TAIL,
                        {$urandom, $urandom}, VCHW'($urandom));
            oready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                sel_mode = 1'($urandom);
                sel = SELW'($urandom_range(0, 5));
            end
            applyStimulus("rand");
            if (expXfer) begin
                if (pos[expGrant] == len[expGrant] + 1) begin
                    pos[expGrant] = 0;
                    len[expGrant] = $urandom_range(0, 3);
                end else begin
                    pos[expGrant]++;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
